// File: rtl/botoes_pkg.sv
// rtl/botoes_pkg.sv - shared constants and lowest-set-bit helper for the button front-end
package botoes_pkg;

    localparam int N_BOTOES              = 8;
    localparam int DEBOUNCE_CICLOS_50MHZ = 500000;
    localparam int CNT_W                 = 20;

    // One-hot of the lowest set bit; two's-complement trick keeps it a single adder.
    function automatic logic [N_BOTOES-1:0] menor_bit(input logic [N_BOTOES-1:0] v);
        return v & (~v + {{(N_BOTOES-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/debounce_canal.sv
// rtl/debounce_canal.sv - one button channel: 2-flop synchroniser, debounce counter, press flag
module debounce_canal #(
    parameter int DEBOUNCE_CICLOS = 4,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic b,
    output logic estavel,
    output logic sobe
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            cnt     <= '0;
            estavel <= 1'b0;
            sobe    <= 1'b0;
        end else begin
            sync1 <= b;
            sync2 <= sync1;
            sobe  <= 1'b0;
            if (sync2 == estavel) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                estavel <= sync2;
                cnt     <= '0;
                // only the 0->1 transition counts as a press
                sobe    <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/botoes_debouncer.sv
// rtl/botoes_debouncer.sv - debounced buttons serialised into one-hot toggle pulses plus move counter
module botoes_debouncer #(
    parameter int N_BOTOES        = botoes_pkg::N_BOTOES,
    parameter int DEBOUNCE_CICLOS = botoes_pkg::DEBOUNCE_CICLOS_50MHZ,
    parameter int CNT_W           = botoes_pkg::CNT_W,
    parameter bit ATIVO_BAIXO     = 1'b1,
    parameter int JOG_W           = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rst_niv,
    input  logic [N_BOTOES-1:0] botoes_in,
    output logic [N_BOTOES-1:0] botoes,
    output logic                pulso_valido,
    output logic [N_BOTOES-1:0] estavel,
    output logic [JOG_W-1:0]    jogadas
);

    import botoes_pkg::*;

    logic [N_BOTOES-1:0] b;
    logic [N_BOTOES-1:0] sobe;
    logic [N_BOTOES-1:0] pendente;
    logic [N_BOTOES-1:0] proximo;

    assign b = ATIVO_BAIXO ? ~botoes_in : botoes_in;

    for (genvar i = 0; i < N_BOTOES; i++) begin : g_canal
        debounce_canal #(
            .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS),
            .CNT_W          (CNT_W)
        ) u_canal (
            .clk    (clk),
            .rst    (rst),
            .b      (b[i]),
            .estavel(estavel[i]),
            .sobe   (sobe[i])
        );
    end

    assign proximo = menor_bit(pendente);

    // Level restart only flushes the event path; debouncers keep their view of held buttons.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pendente     <= '0;
            botoes       <= '0;
            pulso_valido <= 1'b0;
            jogadas      <= '0;
        end else if (!rst_niv) begin
            pendente     <= '0;
            botoes       <= '0;
            pulso_valido <= 1'b0;
            jogadas      <= '0;
        end else begin
            pendente     <= (pendente & ~proximo) | sobe;
            botoes       <= proximo;
            pulso_valido <= |pendente;
            if ((|pendente) && (jogadas != {JOG_W{1'b1}}))
                jogadas <= jogadas + 1'b1;
        end
    end

endmodule

// File: tb/tb_botoes_debouncer.sv
// tb/tb_botoes_debouncer.sv - randomized and directed bench against a history-window reference model
module tb_botoes_debouncer;

    localparam int N  = 8;
    localparam int D  = 4;
    localparam int CW = 3;
    localparam int JW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          rst_niv;
    logic [N-1:0]  press;
    logic [N-1:0]  botoes_in;
    logic [N-1:0]  botoes;
    logic          pulso_valido;
    logic [N-1:0]  estavel;
    logic [JW-1:0] jogadas;

    assign botoes_in = ~press;

    always #5 clk = ~clk;

    botoes_debouncer #(
        .N_BOTOES       (N),
        .DEBOUNCE_CICLOS(D),
        .CNT_W          (CW),
        .ATIVO_BAIXO    (1'b1),
        .JOG_W          (JW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rst_niv     (rst_niv),
        .botoes_in   (botoes_in),
        .botoes      (botoes),
        .pulso_valido(pulso_valido),
        .estavel     (estavel),
        .jogadas     (jogadas)
    );

    int checks = 0;
    int errors = 0;
    int ciclo  = 0;
    int t0;

    bit [N-1:0]  m_est, m_rose, m_pend, m_out;
    bit [JW-1:0] m_jog;
    bit [N-1:0]  hist[$];
    int          pulso_t[$];
    bit [N-1:0]  pulso_v[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @ciclo %0d: got %0h, expected %0h", tag, ciclo, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_est = '0; m_rose = '0; m_pend = '0; m_out = '0; m_jog = '0;
        hist.delete();
        repeat (D + 1) hist.push_back('0);
    endtask

    // hist[k] is the pressed level sampled k+1 edges ago; an accepted change needs D equal samples two edges old.
    task automatic model_step();
        bit [N-1:0] ne, nr, no;
        bit v, same;
        ne = m_est;
        nr = '0;
        for (int i = 0; i < N; i++) begin
            v = hist[1][i];
            same = 1'b1;
            for (int j = 2; j <= D; j++)
                if (hist[j][i] != v) same = 1'b0;
            if (same && v != m_est[i]) begin
                ne[i] = v;
                nr[i] = v;
            end
        end
        no = '0;
        if (rst_niv)
            for (int i = N - 1; i >= 0; i--)
                if (m_pend[i]) begin no = '0; no[i] = 1'b1; end
        if (!rst_niv) begin
            m_pend = '0;
            m_jog  = '0;
        end else begin
            m_pend = (m_pend & ~no) | m_rose;
            if (no != 0 && m_jog != '1) m_jog = m_jog + 1'b1;
        end
        m_out  = no;
        m_est  = ne;
        m_rose = nr;
        hist.push_front(press);
        void'(hist.pop_back());
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        ciclo++;
        check_eq("botoes", botoes, m_out);
        check_eq("pulso_valido", pulso_valido, |m_out);
        check_eq("estavel", estavel, m_est);
        check_eq("jogadas", jogadas, m_jog);
        check_eq("um_bit", ($countones(botoes) <= 1), 1);
        if (botoes != 0) begin
            pulso_t.push_back(ciclo);
            pulso_v.push_back(botoes);
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic limpa_pulsos();
        pulso_t.delete();
        pulso_v.delete();
        t0 = ciclo;
    endtask

    task automatic reinicia_nivel();
        rst_niv = 1'b0;
        tick();
        rst_niv = 1'b1;
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b0;
        model_reset();
        #1;
        check_eq({tag, "_botoes"}, botoes, 0);
        check_eq({tag, "_pulso"}, pulso_valido, 0);
        check_eq({tag, "_estavel"}, estavel, 0);
        check_eq({tag, "_jogadas"}, jogadas, 0);
        #1 rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        rst_niv = 1'b1;
        press = '0;
        model_reset();
        #3;
        check_eq("reset_botoes", botoes, 0);
        check_eq("reset_pulso", pulso_valido, 0);
        check_eq("reset_estavel", estavel, 0);
        check_eq("reset_jogadas", jogadas, 0);
        #4 rst = 1'b1;

        // single held press: one pulse after edge 7, none on release
        limpa_pulsos();
        press[3] = 1'b1;
        run(50);
        check_eq("s1_n_pulsos", pulso_t.size(), 1);
        if (pulso_t.size() >= 1) begin
            check_eq("s1_borda", pulso_t[0] - t0 - 1, 7);
            check_eq("s1_valor", pulso_v[0], 8'h08);
        end
        check_eq("s1_jogadas", jogadas, 1);
        check_eq("s1_estavel", estavel, 8'h08);
        press[3] = 1'b0;
        run(20);
        check_eq("s1_soltar", pulso_t.size(), 1);
        check_eq("s1_estavel_solto", estavel, 0);

        // short glitches never qualify
        reinicia_nivel();
        limpa_pulsos();
        repeat (5) begin
            press[0] = 1'b1; run(3);
            press[0] = 1'b0; run(3);
        end
        run(10);
        check_eq("s2_pulsos", pulso_t.size(), 0);
        check_eq("s2_jogadas", jogadas, 0);
        check_eq("s2_estavel", estavel, 0);

        // simultaneous presses are serialised lowest index first
        limpa_pulsos();
        press[2] = 1'b1; press[5] = 1'b1;
        run(20);
        check_eq("s3_n_pulsos", pulso_t.size(), 2);
        if (pulso_t.size() == 2) begin
            check_eq("s3_v0", pulso_v[0], 8'h04);
            check_eq("s3_v1", pulso_v[1], 8'h20);
            check_eq("s3_seguidos", pulso_t[1] - pulso_t[0], 1);
        end
        check_eq("s3_jogadas", jogadas, 2);
        press = '0;
        run(15);

        // all eight, then again to saturate the counter
        reinicia_nivel();
        limpa_pulsos();
        press = '1;
        run(25);
        check_eq("s4_n_pulsos", pulso_t.size(), 8);
        if (pulso_t.size() == 8)
            for (int k = 0; k < 8; k++) begin
                check_eq("s4_valor", pulso_v[k], 32'(1) << k);
                check_eq("s4_tempo", pulso_t[k] - pulso_t[0], k);
            end
        check_eq("s4_jogadas", jogadas, 8);
        press = '0;
        run(15);
        press = '1;
        run(25);
        check_eq("s4_saturado", jogadas, 15);
        press = '0;
        run(15);

        // level restart with a held button
        reinicia_nivel();
        press = 8'h1F;
        run(25);
        check_eq("s5_jogadas5", jogadas, 5);
        press = 8'h02;
        run(10);
        limpa_pulsos();
        reinicia_nivel();
        check_eq("s5_jog_zero", jogadas, 0);
        check_eq("s5_botoes_zero", botoes, 0);
        run(20);
        check_eq("s5_sem_refogo", pulso_t.size(), 0);
        press[4] = 1'b1;
        run(20);
        check_eq("s5_n_pulsos", pulso_t.size(), 1);
        if (pulso_t.size() == 1) check_eq("s5_valor", pulso_v[0], 8'h10);
        check_eq("s5_jogadas", jogadas, 1);
        press = '0;
        run(15);

        // async reset mid-pending, then mid-debounce, then held re-debounce
        press = 8'hF0;
        run(8);
        async_reset("s6_pend");
        press = 8'h40;
        run(4);
        async_reset("s6_deb");
        limpa_pulsos();
        run(30);
        check_eq("s6_n_pulsos", pulso_t.size(), 1);
        if (pulso_t.size() == 1) begin
            check_eq("s6_borda", pulso_t[0] - t0 - 1, 7);
            check_eq("s6_valor", pulso_v[0], 8'h40);
        end
        press = '0;
        run(15);

        // random phase against the model
        repeat (200) begin
            case ($urandom_range(0, 19))
                0:       reinicia_nivel();
                1:       async_reset("rnd");
                default: press[$urandom_range(0, N - 1)] ^= 1'b1;
            endcase
            run($urandom_range(1, 9));
        end
        press = '0;
        run(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
